bram_arbiter: RTL

Two-requester arbiter that shares one simple-dual-port block RAM (one read port, one write port, 1-cycle registered read, write-forwarding on same-address read/write) between two masters, e.g. core data port and program loader/debug port. Read port and write port are arbitrated independently each cycle with separate round-robin pointers, so a read from one requester and a write from the other complete in the same cycle. The arbiter tracks in-flight reads and routes the returning read data to the requester that issued it.

---
 rtl/bram_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// -----------------------------------------------------------------------------
// bram_arbiter
//
// Shares one simple-dual-port block RAM between two requesters. The RAM has
// one read port and one write port, a 1-cycle registered read, and forwards
// write data on a same-address read/write. Each RAM port has its own
// round-robin arbiter, so a read by one requester and a write by the other
// are both granted in the same cycle. A one-deep tracker remembers who owns
// the read in flight and steers the returning RAM data to that requester.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   rN_valid/write        : requester N operation present / 1 = write
//   rN_address/writeData  : requester N word address / write data
//   rN_ready              : combinational grant (accepted on valid & ready)
//   rN_readValid/readData : read return for requester N (data 0 when idle)
//   mem_read*             : RAM read port (enable, address, registered data)
//   mem_write*            : RAM write port (enable, address, data)
// -----------------------------------------------------------------------------
module bram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  r0_valid,
    input  logic                  r0_write,
    input  logic [ADDR_WIDTH-1:0] r0_address,
    input  logic [DATA_WIDTH-1:0] r0_writeData,
    output logic                  r0_ready,
    output logic                  r0_readValid,
    output logic [DATA_WIDTH-1:0] r0_readData,

    input  logic                  r1_valid,
    input  logic                  r1_write,
    input  logic [ADDR_WIDTH-1:0] r1_address,
    input  logic [DATA_WIDTH-1:0] r1_writeData,
    output logic                  r1_ready,
    output logic                  r1_readValid,
    output logic [DATA_WIDTH-1:0] r1_readData,

    output logic                  mem_readEnable,
    output logic [ADDR_WIDTH-1:0] mem_readAddress,
    input  logic [DATA_WIDTH-1:0] mem_readData,
    output logic                  mem_writeEnable,
    output logic [ADDR_WIDTH-1:0] mem_writeAddress,
    output logic [DATA_WIDTH-1:0] mem_writeData
);

    // Requester-indexed views of the port bundles
    logic                  w_valid  [2];
    logic                  w_write  [2];
    logic [ADDR_WIDTH-1:0] w_addr   [2];
    logic [DATA_WIDTH-1:0] w_wdata  [2];
    logic                  w_ready  [2];
    logic                  w_rvalid [2];
    logic [DATA_WIDTH-1:0] w_rdata  [2];

    assign w_valid[0] = r0_valid;
    assign w_valid[1] = r1_valid;
    assign w_write[0] = r0_write;
    assign w_write[1] = r1_write;
    assign w_addr[0]  = r0_address;
    assign w_addr[1]  = r1_address;
    assign w_wdata[0] = r0_writeData;
    assign w_wdata[1] = r1_writeData;

    // Round-robin pointers (value = favoured requester) and read tracker
    logic r_rd_ptr;
    logic r_wr_ptr;
    logic r_rd_v;
    logic r_rd_id;

    logic [1:0] w_rd_cand;
    logic [1:0] w_wr_cand;
    logic       w_rd_any;
    logic       w_rd_idx;
    logic       w_wr_any;
    logic       w_wr_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cand
            assign w_rd_cand[gi] = w_valid[gi] & ~w_write[gi];
            assign w_wr_cand[gi] = w_valid[gi] &  w_write[gi];
        end
    endgenerate

    // Per-port arbitration. Reset suppresses every grant so nothing reaches
    // the RAM while reset is held. With a single candidate the index is
    // simply bit 1 of the candidate vector.
    always_comb begin
        w_rd_any = ~reset & (|w_rd_cand);
        w_wr_any = ~reset & (|w_wr_cand);
        w_rd_idx = (&w_rd_cand) ? r_rd_ptr : w_rd_cand[1];
        w_wr_idx = (&w_wr_cand) ? r_wr_ptr : w_wr_cand[1];
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            // A requester targets only one port at a time, so OR-ing the
            // two port grants gives its ready.
            assign w_ready[gi]  = (w_rd_any & (w_rd_idx == 1'(gi))) |
                                  (w_wr_any & (w_wr_idx == 1'(gi)));
            assign w_rvalid[gi] = r_rd_v & (r_rd_id == 1'(gi));
            assign w_rdata[gi]  = w_rvalid[gi] ? mem_readData : '0;
        end
    endgenerate

    assign r0_ready     = w_ready[0];
    assign r1_ready     = w_ready[1];
    assign r0_readValid = w_rvalid[0];
    assign r1_readValid = w_rvalid[1];
    assign r0_readData  = w_rdata[0];
    assign r1_readData  = w_rdata[1];

    // RAM drive: idle ports present zeros rather than a stale requester
    assign mem_readEnable   = w_rd_any;
    assign mem_readAddress  = w_rd_any ? w_addr[w_rd_idx]  : '0;
    assign mem_writeEnable  = w_wr_any;
    assign mem_writeAddress = w_wr_any ? w_addr[w_wr_idx]  : '0;
    assign mem_writeData    = w_wr_any ? w_wdata[w_wr_idx] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_rd_v   <= 1'b0;
            r_rd_id  <= 1'b0;
        end else begin
            // Favour the loser next time; hold when the port was idle
            if (w_rd_any) r_rd_ptr <= ~w_rd_idx;
            if (w_wr_any) r_wr_ptr <= ~w_wr_idx;
            r_rd_v  <= w_rd_any;
            r_rd_id <= w_rd_idx;
        end
    end

endmodule
